// File: rtl/enigma_pkg.sv
// Shared constants, symbol type and modular helper for the Enigma rotor core.
package enigma_pkg;

    localparam int ALPHA_DEF = 26;
    localparam int POS_W     = 5;

    typedef logic [POS_W-1:0] sym_t;

    // Expects a < m and b < m; one conditional subtract is enough.
    function automatic sym_t mod_add(input sym_t a, input sym_t b, input logic [POS_W:0] m);
        logic [POS_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= m) begin
            s = s - m;
        end
        return s[POS_W-1:0];
    endfunction

endpackage

// File: rtl/enigma_step_unit.sv
// Combinational rotor step flags and next positions for one accepted symbol.
// Double stepping of middle rotors is enabled by defining ENIGMA_DOUBLE_STEP_EN.
module enigma_step_unit
    import enigma_pkg::*;
#(
    parameter int N_ROT = 3,
    parameter int ALPHA = ALPHA_DEF
) (
    input  logic [POS_W*N_ROT-1:0] pos,
    output logic [N_ROT-1:0]       step,
    output logic [POS_W*N_ROT-1:0] pos_next
);

    localparam logic [POS_W:0] MOD = (POS_W+1)'(ALPHA);
    localparam sym_t           TOP = sym_t'(ALPHA - 1);

    always_comb begin
        logic [N_ROT-1:0] s;
        s        = '0;
        s[0]     = 1'b1;
        pos_next = pos;
        for (int k = 1; k < N_ROT; k++) begin
            s[k] = s[k-1] && (pos[POS_W*(k-1) +: POS_W] == TOP);
`ifdef ENIGMA_DOUBLE_STEP_EN
            // A middle rotor sitting on its notch steps itself and drags the next one.
            if ((k <= N_ROT - 2) && (pos[POS_W*k +: POS_W] == TOP)) begin
                s[k] = 1'b1;
            end
            if ((k >= 2) && (pos[POS_W*(k-1) +: POS_W] == TOP)) begin
                s[k] = 1'b1;
            end
`endif
        end
        for (int k = 0; k < N_ROT; k++) begin
            if (s[k]) begin
                pos_next[POS_W*k +: POS_W] = mod_add(pos[POS_W*k +: POS_W], sym_t'(1), MOD);
            end
        end
        step = s;
    end

endmodule

// File: rtl/enigma_rotor_core.sv
// Enigma-style rotor core: rotor stepping in front of a two-stage encrypt pipeline.
// Optional middle-rotor double stepping is enabled by ENIGMA_DOUBLE_STEP_EN.
module enigma_rotor_core
    import enigma_pkg::*;
#(
    parameter int N_ROT = 3,
    parameter int ALPHA = ALPHA_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_load,
    input  logic [POS_W*N_ROT-1:0] cfg_pos,
    input  logic                   valid_in,
    input  logic [POS_W-1:0]       char_in,
    output logic                   in_ready,
    output logic [POS_W-1:0]       char_out,
    output logic                   valid_out,
    input  logic                   out_ready,
    output logic [POS_W*N_ROT-1:0] pos_out
);

    localparam logic [POS_W:0] MOD = (POS_W+1)'(ALPHA);
    localparam sym_t           TOP = sym_t'(ALPHA - 1);

    logic [POS_W*N_ROT-1:0] pos_q;
    logic [POS_W*N_ROT-1:0] pos_next;
    logic [POS_W*N_ROT-1:0] cfg_mod;
    logic [N_ROT-1:0]       step;
    logic                   s1_valid;
    logic                   s1_pass;
    sym_t                   s1_sym;
    sym_t                   s1_sum;
    logic                   s2_free;
    logic                   accept;
    logic                   pass_in;
    sym_t                   sum_next;
    sym_t                   enc;

    // Handshake: a symbol moves on an edge where valid && ready; once valid_out is
    // raised, valid_out and char_out hold until out_ready takes the symbol.
    assign s2_free  = !valid_out || out_ready;
    assign in_ready = !cfg_load && (!s1_valid || s2_free);
    assign accept   = valid_in && in_ready;
    assign pass_in  = {1'b0, char_in} >= MOD;
    assign pos_out  = pos_q;

    enigma_step_unit #(
        .N_ROT(N_ROT),
        .ALPHA(ALPHA)
    ) u_step (
        .pos     (pos_q),
        .step    (step),
        .pos_next(pos_next)
    );

    // S uses post-step positions; the reflector folds the whole rotor path into one subtract.
    always_comb begin
        sum_next = '0;
        cfg_mod  = '0;
        for (int k = 0; k < N_ROT; k++) begin
            sum_next = mod_add(sum_next, pos_next[POS_W*k +: POS_W], MOD);
            cfg_mod[POS_W*k +: POS_W] = sym_t'({1'b0, cfg_pos[POS_W*k +: POS_W]} % MOD);
        end
        enc = TOP - mod_add(s1_sym, mod_add(s1_sum, s1_sum, MOD), MOD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_q     <= '0;
            s1_valid  <= 1'b0;
            s1_pass   <= 1'b0;
            s1_sym    <= '0;
            s1_sum    <= '0;
            valid_out <= 1'b0;
            char_out  <= '0;
        end else begin
            if (cfg_load) begin
                pos_q <= cfg_mod;
            end else if (accept && !pass_in) begin
                for (int k = 0; k < N_ROT; k++) begin
                    if (step[k]) begin
                        pos_q[POS_W*k +: POS_W] <= pos_next[POS_W*k +: POS_W];
                    end
                end
            end

            if (accept) begin
                s1_valid <= 1'b1;
                s1_pass  <= pass_in;
                s1_sym   <= char_in;
                s1_sum   <= sum_next;
            end else if (s1_valid && s2_free) begin
                s1_valid <= 1'b0;
            end

            if (s2_free) begin
                valid_out <= s1_valid;
                if (s1_valid) begin
                    char_out <= s1_pass ? s1_sym : enc;
                end
            end
        end
    end

endmodule

// File: tb/tb_enigma_rotor_core.sv
// Self-checking bench for enigma_rotor_core (N_ROT=3, ALPHA=26).
// Honours ENIGMA_DOUBLE_STEP_EN in its reference model and expectations.
module tb_enigma_rotor_core;

    localparam int N_ROT = 3;
    localparam int ALPHA = 26;
    localparam int W     = 5;

    logic                 clk       = 1'b0;
    logic                 rst       = 1'b0;
    logic                 cfg_load  = 1'b0;
    logic [W*N_ROT-1:0]   cfg_pos   = '0;
    logic                 valid_in  = 1'b0;
    logic [W-1:0]         char_in   = '0;
    logic                 out_ready = 1'b1;
    logic                 in_ready;
    logic [W-1:0]         char_out;
    logic                 valid_out;
    logic [W*N_ROT-1:0]   pos_out;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           mp[N_ROT];

    logic         stall_prev = 1'b0;
    logic [W-1:0] prev_char  = '0;
    logic [W-1:0] exp_v;

    enigma_rotor_core #(
        .N_ROT(N_ROT),
        .ALPHA(ALPHA)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_load (cfg_load),
        .cfg_pos  (cfg_pos),
        .valid_in (valid_in),
        .char_in  (char_in),
        .in_ready (in_ready),
        .char_out (char_out),
        .valid_out(valid_out),
        .out_ready(out_ready),
        .pos_out  (pos_out)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [W*N_ROT-1:0] model_pos();
        return {W'(mp[2]), W'(mp[1]), W'(mp[0])};
    endfunction

    task automatic model_accept(input logic [W-1:0] c);
        int st[N_ROT];
        int s;
        int v;
        if (int'(c) >= ALPHA) begin
            exp_q.push_back(c);
            return;
        end
        st[0] = 1;
        for (int k = 1; k < N_ROT; k++) begin
            st[k] = (st[k-1] == 1 && mp[k-1] == ALPHA - 1) ? 1 : 0;
`ifdef ENIGMA_DOUBLE_STEP_EN
            if (k <= N_ROT - 2 && mp[k] == ALPHA - 1) st[k] = 1;
            if (k >= 2 && mp[k-1] == ALPHA - 1) st[k] = 1;
`endif
        end
        s = 0;
        for (int k = 0; k < N_ROT; k++) begin
            if (st[k] == 1) mp[k] = (mp[k] + 1) % ALPHA;
            s = s + mp[k];
        end
        s = s % ALPHA;
        v = ((ALPHA - 1 - int'(c) - 2 * s) % ALPHA + ALPHA) % ALPHA;
        exp_q.push_back(W'(v));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            if (stall_prev) begin
                n_tests++;
                if (valid_out !== 1'b1 || char_out !== prev_char) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid_out=%b char_out=%0d, required 1 / %0d", valid_out, char_out, prev_char);
                end
            end
            if (valid_out === 1'b1 && out_ready === 1'b1) begin
                got_q.push_back(char_out);
                n_out++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: char_out=%0d, required no output", char_out);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (char_out !== exp_v) begin
                        n_fail++;
                        $display("FAIL output_data: char_out=%0d, required %0d", char_out, exp_v);
                    end
                end
            end
            stall_prev = (valid_out === 1'b1) && (out_ready === 1'b0);
            prev_char  = char_out;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // ---------------- driver tasks (entered and left at posedge+1) ----------------
    task automatic model_clear();
        exp_q.delete();
        got_q.delete();
        for (int k = 0; k < N_ROT; k++) mp[k] = 0;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        valid_in  = 1'b0;
        cfg_load  = 1'b0;
        out_ready = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic send(input logic [W-1:0] c);
        int guard;
        guard    = 0;
        valid_in = 1'b1;
        char_in  = c;
        @(negedge clk);
        while (in_ready !== 1'b1 && guard < 100) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%b, required 1 within 100 cycles", in_ready);
        end else begin
            model_accept(c);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d outputs outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input int p0, input int p1, input int p2, input bit with_valid);
        cfg_pos  = {W'(p2), W'(p1), W'(p0)};
        cfg_load = 1'b1;
        if (with_valid) begin
            valid_in = 1'b1;
            char_in  = 5'd3;
        end
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_in_ready: in_ready=%b, required 0", in_ready);
        end
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        valid_in = 1'b0;
        mp[0] = p0 % ALPHA;
        mp[1] = p1 % ALPHA;
        mp[2] = p2 % ALPHA;
        n_tests++;
        if (pos_out !== model_pos()) begin
            n_fail++;
            $display("FAIL load_pos: pos_out=%h, required %h", pos_out, model_pos());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (valid_out !== 1'b0 || char_out !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid_out=%b char_out=%0d, required 0 / 0", valid_out, char_out);
        end
        n_tests++;
        if (pos_out !== '0) begin
            n_fail++;
            $display("FAIL reset_pos: pos_out=%h, required 0", pos_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        do_reset();
        valid_in = 1'b1;
        char_in  = 5'd0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_in_ready: in_ready=%b, required 1", in_ready);
        end
        model_accept(5'd0);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        n_tests++;
        if (pos_out !== {5'd0, 5'd0, 5'd1}) begin
            n_fail++;
            $display("FAIL basic_pos: pos_out=%h, required %h", pos_out, {5'd0, 5'd0, 5'd1});
        end
        @(negedge clk);
        n_tests++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency_early: valid_out=%b, required 0", valid_out);
        end
        @(negedge clk);
        n_tests++;
        if (valid_out !== 1'b1 || char_out !== 5'd23) begin
            n_fail++;
            $display("FAIL basic_encrypt: valid_out=%b char_out=%0d, required 1 / 23", valid_out, char_out);
        end
        drain();
    endtask

    task automatic test_involution();
        logic [W-1:0] plain[$];
        logic [W-1:0] cipher[$];
        int a, b, c;
        do_reset();
        send(5'd23);
        drain();
        n_tests++;
        if (got_q.size() != 1 || got_q[0] !== 5'd0) begin
            n_fail++;
            $display("FAIL involution_23: got %0d outputs first=%0d, required 1 / 0", got_q.size(), (got_q.size() > 0) ? got_q[0] : 5'd31);
        end
        a = $urandom_range(0, 25);
        b = $urandom_range(0, 25);
        c = $urandom_range(0, 25);
        load_cfg(a, b, c, 1'b0);
        got_q.delete();
        for (int i = 0; i < 200; i++) plain.push_back(W'($urandom_range(0, 25)));
        for (int i = 0; i < 200; i++) send(plain[i]);
        drain();
        cipher = got_q;
        n_tests++;
        if (cipher.size() != 200) begin
            n_fail++;
            $display("FAIL involution_count1: got %0d outputs, required 200", cipher.size());
        end else begin
            for (int i = 0; i < 200; i++) begin
                n_tests++;
                if (cipher[i] === plain[i]) begin
                    n_fail++;
                    $display("FAIL involution_fixed_point: idx %0d out=%0d, required not %0d", i, cipher[i], plain[i]);
                end
            end
            load_cfg(a, b, c, 1'b0);
            got_q.delete();
            for (int i = 0; i < 200; i++) send(cipher[i]);
            drain();
            n_tests++;
            if (got_q.size() != 200) begin
                n_fail++;
                $display("FAIL involution_count2: got %0d outputs, required 200", got_q.size());
            end else begin
                for (int i = 0; i < 200; i++) begin
                    n_tests++;
                    if (got_q[i] !== plain[i]) begin
                        n_fail++;
                        $display("FAIL involution_roundtrip: idx %0d got %0d, required %0d", i, got_q[i], plain[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_carry();
        load_cfg(25, 25, 0, 1'b0);
        send(5'd7);
        n_tests++;
        if (pos_out !== {5'd1, 5'd0, 5'd0}) begin
            n_fail++;
            $display("FAIL carry_pos: pos_out=%h, required %h", pos_out, {5'd1, 5'd0, 5'd0});
        end
        drain();
    endtask

    task automatic test_double_step();
        logic [W*N_ROT-1:0] want;
`ifdef ENIGMA_DOUBLE_STEP_EN
        want = {5'd1, 5'd0, 5'd25};
`else
        want = {5'd0, 5'd25, 5'd25};
`endif
        load_cfg(24, 25, 0, 1'b0);
        send(5'd4);
        n_tests++;
        if (pos_out !== want) begin
            n_fail++;
            $display("FAIL double_step_pos: pos_out=%h, required %h", pos_out, want);
        end
        drain();
    endtask

    task automatic test_wrap();
        load_cfg(25, 25, 25, 1'b0);
        send(5'd11);
        n_tests++;
        if (pos_out !== '0) begin
            n_fail++;
            $display("FAIL wrap_pos: pos_out=%h, required 0", pos_out);
        end
        drain();
    endtask

    task automatic test_passthrough();
        load_cfg(5, 6, 7, 1'b0);
        send(5'd30);
        n_tests++;
        if (pos_out !== {5'd7, 5'd6, 5'd5}) begin
            n_fail++;
            $display("FAIL passthrough_pos: pos_out=%h, required %h", pos_out, {5'd7, 5'd6, 5'd5});
        end
        drain();
        n_tests++;
        if (got_q.size() == 0 || got_q[got_q.size()-1] !== 5'd30) begin
            n_fail++;
            $display("FAIL passthrough_data: last output=%0d, required 30", (got_q.size() > 0) ? got_q[got_q.size()-1] : 5'd0);
        end
    endtask

    task automatic test_load_edge();
        load_cfg(30, 1, 2, 1'b1);
        n_tests++;
        if (pos_out !== {5'd2, 5'd1, 5'd4}) begin
            n_fail++;
            $display("FAIL load_mod_pos: pos_out=%h, required %h", pos_out, {5'd2, 5'd1, 5'd4});
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL load_no_accept: valid_out=%b, required 0", valid_out);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int out0;
        do_reset();
        out0 = n_out;
        fork
            begin
                for (int i = 0; i < 10; i++) send(W'(i));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                @(negedge clk);
                n_tests++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL backpressure_in_ready: in_ready=%b, required 0", in_ready);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        n_tests++;
        if (n_out - out0 != 10) begin
            n_fail++;
            $display("FAIL backpressure_count: outputs=%0d, required 10", n_out - out0);
        end
        n_tests++;
        if (pos_out !== model_pos()) begin
            n_fail++;
            $display("FAIL backpressure_pos: pos_out=%h, required %h", pos_out, model_pos());
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        send(5'd1);
        send(5'd2);
        rst = 1'b0;
        model_clear();
        #1;
        n_tests++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_valid: valid_out=%b, required 0", valid_out);
        end
        n_tests++;
        if (pos_out !== '0) begin
            n_fail++;
            $display("FAIL midreset_pos: pos_out=%h, required 0", pos_out);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (valid_out !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_flush: cycle %0d valid_out=%b, required 0", i, valid_out);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_involution();
        test_carry();
        test_double_step();
        test_wrap();
        test_passthrough();
        test_load_edge();
        test_backpressure();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
